// File: rtl/data_mem_ctrl.sv
// Load/store controller: request/ready data-memory handshake, pipeline stall, lane-aligned extended load data.
// Optional watchdog timeout enabled by defining DMEM_TIMEOUT_EN.
module data_mem_ctrl #(
  parameter int ADDR_W         = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_bytes,
  input  logic              req_unsigned,
  output logic              stall,
  output logic [31:0]       dout,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                err_q, err_d;
  logic [31:0]         dout_q, dout_d;

  logic                illegal;
  logic [3:0]          strb;
  logic [31:0]         wdata_rep;
  logic [31:0]         lane;
  logic [31:0]         load_val;
  logic                unused_addr;

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]          cnt_q, cnt_d;
`endif

  assign unused_addr = ^req_addr[31:ADDR_W+2];

  always_comb begin
    illegal   = (req_bytes == 2'b11) ||
                (req_bytes == 2'b01 && req_addr[0]) ||
                (req_bytes == 2'b10 && req_addr[1:0] != 2'b00);
    wdata_rep = req_wdata;
    strb      = 4'b1111;
    case (req_bytes)
      2'b00: begin
        wdata_rep = {4{req_wdata[7:0]}};
        strb      = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wdata_rep = {2{req_wdata[15:0]}};
        strb      = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase

    // Load extraction uses the latched offset/size, not the live request.
    lane     = mem_rdata >> {off_q, 3'b000};
    load_val = lane;
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & lane[7]}},  lane[7:0]};
      2'b01:   load_val = {{16{~uns_q & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    err_d       = err_q;
    dout_d      = dout_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            dout_d  = 32'h0;
          end else begin
            state_d     = S_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_addr[ADDR_W+1:2];
            mem_wdata_d = wdata_rep;
            mem_wstrb_d = req_we ? strb : 4'b0000;
            off_d       = req_addr[1:0];
            size_d      = req_bytes;
            uns_d       = req_unsigned;
`ifdef DMEM_TIMEOUT_EN
            cnt_d       = 8'd0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) dout_d = load_val;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (!mem_we_q) dout_d = 32'hDEADBEEF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      dout_q      <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      err_q       <= err_d;
      dout_q      <= dout_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Stall drops combinationally in DONE so the pipeline advances on that edge.
  assign stall     = req_valid && (state_q != S_DONE);
  assign dout      = dout_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed test-plan cases plus randomized accesses against an arithmetic reference model.
module tb_data_mem_ctrl;
  localparam int ADDR_W = 20;
  localparam int TO_CYC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_we, req_unsigned;
  logic [31:0]       req_addr, req_wdata;
  logic [1:0]        req_bytes;
  logic              stall, err, mem_req, mem_we, mem_ready;
  logic [31:0]       dout, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] dout_exp;
  logic        err_exp;

  data_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_bytes(req_bytes), .req_unsigned(req_unsigned),
    .stall(stall), .dout(dout), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_illegal(input logic [31:0] a, input logic [1:0] b);
    return (b == 2'd3) || (b == 2'd1 && a % 2 != 0) || (b == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] b, input logic uns);
    longint unsigned n, v;
    n = 64'd8 << b;
    v = ({32'h0, rd} >> (8 * (a % 4))) % (64'd1 << n);
    if (!uns && v >= (64'd1 << (n - 1))) v = v - (64'd1 << n);
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_strb(input logic we, input logic [31:0] a, input logic [1:0] b);
    int s;
    if (!we) return 32'h0;
    s = ((1 << (1 << b)) - 1) << (a % 4);
    return 32'(s[3:0]);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] w, input logic [1:0] b);
    if (b == 2'd0) return w[7:0] * 32'h0101_0101;
    if (b == 2'd1) return w[15:0] * 32'h0001_0001;
    return w;
  endfunction

  // Entered and left at posedge+1; memory answers `delay` cycles after it first sees mem_req.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] bytes, input logic uns, input logic [31:0] rdata,
                        input int delay, input bit expect_to, input string tag);
    logic ill, seen;
    int   cyc, wcnt, exp_cyc;
    ill = is_illegal(addr, bytes);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_bytes = bytes; req_unsigned = uns; mem_ready = 1'b0;
    cyc = 0; wcnt = 0; seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!stall) break;
      cyc++;
      if (mem_req) begin
        if (!seen) begin
          check({tag, "_we"}, mem_we, we);
          check({tag, "_addr"}, mem_addr, (addr >> 2) & ((32'd1 << ADDR_W) - 1));
          check({tag, "_strb"}, mem_wstrb, exp_strb(we, addr, bytes));
          if (we) check({tag, "_wdata"}, mem_wdata, exp_wdata(wdata, bytes));
        end
        seen = 1'b1;
        if (wcnt == delay) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
        end
        wcnt++;
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    if (ill) begin
      err_exp = 1'b1; dout_exp = 32'h0; exp_cyc = 1;
    end else if (expect_to) begin
      err_exp = 1'b1; exp_cyc = 1 + TO_CYC;
      if (!we) dout_exp = 32'hDEADBEEF;
    end else begin
      exp_cyc = delay + 2;
      if (!we) dout_exp = exp_load(rdata, addr, bytes, uns);
    end
    check({tag, "_stall_cycles"}, cyc, exp_cyc);
    check({tag, "_req_seen"}, seen, !ill);
    check({tag, "_req_drop"}, mem_req, 1'b0);
    check({tag, "_dout"}, dout, dout_exp);
    check({tag, "_err"}, err, err_exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  b;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_bytes = 2'b00; req_unsigned = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    dout_exp = 32'h0; err_exp = 1'b0;
    #2;
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", mem_wstrb, 32'h0);
    check("rst_dout", dout, 32'h0);
    check("rst_err", err, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    access(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'h8000_00F0, 0, 1'b0, "tp_lw");
    check("tp_lw_value", dout, 32'h8000_00F0);
    access(1'b1, 32'h3, 32'hAB, 2'd0, 1'b0, 32'h0, 1, 1'b0, "tp_sb");
    check("tp_sb_dout_kept", dout, 32'h8000_00F0);
    access(1'b0, 32'h2, 32'h0, 2'd0, 1'b0, 32'h0080_0000, 0, 1'b0, "tp_lb");
    check("tp_lb_value", dout, 32'hFFFF_FF80);
    access(1'b0, 32'h2, 32'h0, 2'd0, 1'b1, 32'h0080_0000, 2, 1'b0, "tp_lbu");
    check("tp_lbu_value", dout, 32'h0000_0080);
    access(1'b0, 32'h1, 32'h0, 2'd1, 1'b0, 32'h0, 0, 1'b0, "tp_lh_mis");
    check("tp_lh_mis_err", err, 1'b1);

    // Word load abandoned by reset in the third WAIT cycle.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_bytes = 2'd2; req_unsigned = 1'b0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_req_before", mem_req, 1'b1);
    rst = 1'b1; req_valid = 1'b0;
    #1;
    err_exp = 1'b0; dout_exp = 32'h0;
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_we", mem_we, 1'b0);
    check("mid_rst_dout", dout, 32'h0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 32'h24, 32'h0, 2'd2, 1'b0, 32'h1234_5678, 5, 1'b0, "post_rst_lw");

    for (int k = 0; k < 80; k++) begin
      b = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0 && b != 2'd3) a = a & ~((32'd1 << b) - 1);
      access(1'($urandom_range(0, 1)), a, $urandom, b, 1'($urandom_range(0, 1)),
             $urandom, $urandom_range(0, 3), 1'b0, "rnd");
      mem_ready = 1'b1; mem_rdata = $urandom;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      check("rnd_idle_ready_ignored", dout, dout_exp);
      check("rnd_idle_stall", stall, 1'b0);
    end

`ifdef DMEM_TIMEOUT_EN
    access(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 32'h0, 1000, 1'b1, "timeout_lw");
    check("timeout_dout", dout, 32'hDEADBEEF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
